// File: rtl/ram_pkg.sv
// Shared definitions for the wait-state RAM: state encoding, enable levels and default parameters.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_DEPTH       = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 0;

  // Wide enough for the largest wait-state setting (15).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ram_wait_counter.sv
// Down-counter that paces the wait states; zero flags the final wait cycle.
module ram_wait_counter
  import ram_pkg::*;
#(
  parameter int WIDTH = WAIT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load == ENABLE) begin
      count <= value;
    end else if (enable == ENABLE && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sync_wait_ram.sv
// Single-port RAM with configurable wait states, byte-lane writes and a one-cycle acknowledge.
// Define RAM_RANGE_CHECK_EN to flag and suppress accesses whose word index is >= DEPTH.
module sync_wait_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_enable,
  input  logic                    request,
  input  logic                    write_enable,
  input  logic [31:0]             address,
  input  logic [DATA_WIDTH/8-1:0] write_select,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    acknowledge,
  output logic                    busy,
  output logic                    error
);

  localparam int LANES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(LANES);
  localparam int INDEX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t state, state_next;

  logic                  accept;
  logic                  access;
  logic                  cnt_load, cnt_enable, cnt_zero;
  logic [31:0]           word_full;
  logic [INDEX_W-1:0]    index_now;
  logic                  range_ok_now;

  logic                  we_q;
  logic [INDEX_W-1:0]    index_q;
  logic                  range_ok_q;
  logic [LANES-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  op_we;
  logic [INDEX_W-1:0]    op_index;
  logic                  op_range_ok;
  logic [LANES-1:0]      op_sel;
  logic [DATA_WIDTH-1:0] op_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic unused_bits;

  assign word_full   = address >> ADDR_LSB;
  assign index_now   = word_full[INDEX_W-1:0];
  assign unused_bits = ^{address, word_full};

`ifdef RAM_RANGE_CHECK_EN
  assign range_ok_now = (word_full < 32'(DEPTH));
  assign error        = (state == DONE) && !range_ok_q;
`else
  assign range_ok_now = 1'b1;
  assign error        = 1'b0;
`endif

  assign accept      = (state == IDLE) && (chip_enable == ENABLE) && (request == ENABLE);
  assign busy        = (state != IDLE);
  assign acknowledge = (state == DONE);

  // With no wait states the access happens on the accepting edge, so operands come straight from the inputs.
  assign op_we       = (state == IDLE) ? write_enable : we_q;
  assign op_index    = (state == IDLE) ? index_now    : index_q;
  assign op_range_ok = (state == IDLE) ? range_ok_now : range_ok_q;
  assign op_sel      = (state == IDLE) ? write_select : sel_q;
  assign op_wdata    = (state == IDLE) ? write_data   : wdata_q;

  ram_wait_counter #(
    .WIDTH(WAIT_CNT_W)
  ) u_wait_counter (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .value (WAIT_LOAD),
    .enable(cnt_enable),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_next = state;
    cnt_load   = DISABLE;
    cnt_enable = DISABLE;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_load   = ENABLE;
          end else begin
            state_next = DONE;
            access     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_next = DONE;
          access     = 1'b1;
        end else begin
          cnt_enable = ENABLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      index_q    <= '0;
      range_ok_q <= 1'b0;
      sel_q      <= '0;
      wdata_q    <= '0;
      read_data  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q       <= write_enable;
        index_q    <= index_now;
        range_ok_q <= range_ok_now;
        sel_q      <= write_select;
        wdata_q    <= write_data;
      end
      if (access && !op_we) begin
        read_data <= op_range_ok ? mem[op_index] : '0;
      end
    end
  end

  // Storage has no reset; the reset gate keeps an accept during reset from writing.
  always_ff @(posedge clock) begin
    if (access && op_we && op_range_ok && !reset) begin
      for (int b = 0; b < LANES; b++) begin
        if (op_sel[b]) begin
          mem[op_index][b*8 +: 8] <= op_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_wait_ram.sv
// Self-checking bench for sync_wait_ram: three instances with 0, 3 and 5 wait states.
module tb_sync_wait_ram;

  localparam int NDUT = 3;
`ifdef RAM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef struct {
    int          dut;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] rd;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset        [NDUT];
  logic        chip_enable  [NDUT];
  logic        request      [NDUT];
  logic        write_enable [NDUT];
  logic [31:0] address      [NDUT];
  logic [3:0]  write_select [NDUT];
  logic [31:0] write_data   [NDUT];
  logic [31:0] read_data    [NDUT];
  logic        acknowledge  [NDUT];
  logic        busy         [NDUT];
  logic        error        [NDUT];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd_model [NDUT];
  exp_t        sb [$];
  vec_t        vecs [$];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sync_wait_ram #(
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) dut (
      .clock       (clock),
      .reset       (reset[g]),
      .chip_enable (chip_enable[g]),
      .request     (request[g]),
      .write_enable(write_enable[g]),
      .address     (address[g]),
      .write_select(write_select[g]),
      .write_data  (write_data[g]),
      .read_data   (read_data[g]),
      .acknowledge (acknowledge[g]),
      .busy        (busy[g]),
      .error       (error[g])
    );
  end

  function automatic int waitsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input int d, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string name);
    vec_t v;
    v.dut = d; v.we = we; v.addr = addr; v.sel = sel; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  // Pops the oldest expectation and compares it with the acknowledged completion.
  task automatic checkOutput(input int d, input int lat, input int busy_cnt);
    exp_t e;
    if (sb.size() == 0) begin
      checkEq("unexpected_ack", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkEq({e.name, "_dut"},     32'(d),        32'(e.dut));
    checkEq({e.name, "_latency"}, 32'(lat),      32'(e.lat));
    checkEq({e.name, "_busy"},    32'(busy_cnt), 32'(e.lat));
    checkEq({e.name, "_rdata"},   read_data[d],  e.rd);
    checkEq({e.name, "_error"},   32'(error[d]), 32'(e.err));
  endtask

  // Issues one access from a negedge, optionally pulsing junk requests while busy, and waits for the ack.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                               input string name, input bit junk);
    exp_t e;
    int   busy_cnt = 0;
    bit   acked = 0;
    e.dut = d;
    e.rd = we ? rd_model[d] : exp_rd;
    e.err = exp_err;
    e.lat = waitsOf(d) + 1;
    e.name = name;
    sb.push_back(e);
    if (!we) rd_model[d] = exp_rd;
    chip_enable[d] = 1'b1;
    request[d] = 1'b1;
    write_enable[d] = we;
    address[d] = addr;
    write_select[d] = sel;
    write_data[d] = wd;
    for (int k = 1; k <= 30 && !acked; k++) begin
      @(negedge clock);
      if (busy[d]) busy_cnt++;
      if (acknowledge[d]) begin
        checkOutput(d, k, busy_cnt);
        acked = 1;
      end
      if (junk && !acked) begin
        request[d] = ~request[d];
        write_enable[d] = 1'b1;
        address[d] = 32'h8;
        write_select[d] = 4'hF;
        write_data[d] = 32'hFFFF_FFFF;
      end else begin
        request[d] = 1'b0;
      end
    end
    request[d] = 1'b0;
    if (!acked) begin
      checkEq({name, "_ack_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      @(negedge clock);
      checkEq({name, "_idle_after"}, {30'd0, busy[d], acknowledge[d]}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      reset[d] = 1'b1; chip_enable[d] = 1'b0; request[d] = 1'b0; write_enable[d] = 1'b0;
      address[d] = '0; write_select[d] = '0; write_data[d] = '0; rd_model[d] = '0;
    end

    // Table: {dut, we, addr, sel, wdata, expected read data, expected error, name}
    addVec(0, 1, 32'h10,   4'hF,    32'hDEADBEEF, 32'h0,        0, "wr_deadbeef");
    addVec(0, 0, 32'h10,   4'hF,    32'h0,        32'hDEADBEEF, 0, "rd_deadbeef");
    addVec(0, 0, 32'h13,   4'hF,    32'h0,        32'hDEADBEEF, 0, "rd_unaligned");
    addVec(0, 1, 32'h40,   4'hF,    32'h11223344, 32'h0,        0, "wr_base");
    addVec(0, 1, 32'h40,   4'b0101, 32'hAABBCCDD, 32'h0,        0, "wr_lanes");
    addVec(0, 0, 32'h40,   4'hF,    32'h0,        32'h11BB33DD, 0, "rd_lanes");
    addVec(0, 1, 32'h44,   4'hF,    32'h55667788, 32'h0,        0, "wr_full");
    addVec(0, 1, 32'h44,   4'h0,    32'hFFFFFFFF, 32'h0,        0, "wr_nosel");
    addVec(0, 0, 32'h44,   4'hF,    32'h0,        32'h55667788, 0, "rd_nosel");
    addVec(0, 1, 32'h0,    4'hF,    32'h12345678, 32'h0,        0, "wr_word0");
    addVec(0, 1, 32'h1000, 4'hF,    32'hBAD0BAD0, 32'h0,        RANGE_CHECK, "wr_oob");
    addVec(0, 0, 32'h0,    4'hF,    32'h0, RANGE_CHECK ? 32'h12345678 : 32'hBAD0BAD0, 0, "rd_word0");
    addVec(0, 0, 32'h1000, 4'hF,    32'h0, RANGE_CHECK ? 32'h0 : 32'hBAD0BAD0, RANGE_CHECK, "rd_oob");
    addVec(1, 1, 32'h8,    4'hF,    32'hCAFEF00D, 32'h0,        0, "w3_wr");
    addVec(1, 0, 32'h8,    4'hF,    32'h0,        32'hCAFEF00D, 0, "w3_rd");
    addVec(2, 1, 32'h20,   4'hF,    32'h0,        32'h0,        0, "w5_wr_zero");

    repeat (2) @(negedge clock);
    for (int d = 0; d < NDUT; d++)
      checkEq("reset_held", {read_data[d][29:0], acknowledge[d], busy[d]} | 32'(error[d]), 32'd0);
    for (int d = 0; d < NDUT; d++) reset[d] = 1'b0;
    @(negedge clock);
    for (int d = 0; d < NDUT; d++) begin
      checkEq("reset_rdata", read_data[d], 32'h0);
      checkEq("reset_flags", {29'd0, acknowledge[d], busy[d], error[d]}, 32'd0);
    end

    foreach (vecs[i])
      applyStimulus(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wd,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].name, 1'b0);

    // Three wait states with request toggling (as a write to 0x8) while busy; 0x8 must survive.
    applyStimulus(1, 0, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, 0, "w3_rd_junk", 1'b1);
    applyStimulus(1, 0, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, 0, "w3_rd_after_junk", 1'b0);

    // Five wait states: reset lands in the second wait cycle and must abandon the write.
    chip_enable[2] = 1'b1; request[2] = 1'b1; write_enable[2] = 1'b1;
    address[2] = 32'h20; write_select[2] = 4'hF; write_data[2] = 32'hA5A5A5A5;
    @(negedge clock);
    request[2] = 1'b0;
    checkEq("abort_busy_before", 32'(busy[2]), 32'd1);
    @(negedge clock);
    reset[2] = 1'b1;
    #1;
    checkEq("abort_busy_forced", {30'd0, busy[2], acknowledge[2]}, 32'd0);
    @(negedge clock);
    reset[2] = 1'b0;
    rd_model[2] = '0;
    begin
      int acks = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        if (acknowledge[2] || busy[2]) acks++;
      end
      checkEq("abort_no_ack", 32'(acks), 32'd0);
    end
    applyStimulus(2, 0, 32'h20, 4'hF, 32'h0, 32'h0, 0, "w5_rd_after_abort", 1'b0);

    // chip_enable low blocks requests.
    chip_enable[0] = 1'b0; request[0] = 1'b1; write_enable[0] = 1'b1;
    address[0] = 32'h10; write_select[0] = 4'hF; write_data[0] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkEq("ce_low_flags", {30'd0, busy[0], acknowledge[0]}, 32'd0);
    end
    request[0] = 1'b0; chip_enable[0] = 1'b1;
    @(negedge clock);
    checkEq("ce_low_after", {30'd0, busy[0], acknowledge[0]}, 32'd0);
    applyStimulus(0, 0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, "rd_after_ce_low", 1'b0);

    checkEq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_wait_ram.md
SYNC_WAIT_RAM -- requirements
Module: sync_wait_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits; a multiple of 8, at least 8.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of words; a power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning added access wait states; range 0..15.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port chip_enable, input, 1 bit: when low, no new request is accepted.
REQ-007 SHALL have port request, input, 1 bit: access request, sampled only in IDLE.
REQ-008 SHALL have port write_enable, input, 1 bit: 1 = write, 0 = read; captured with the request.
REQ-009 SHALL have port address, input, 32 bits: byte address; word index = address >> log2(DATA_WIDTH/8).
REQ-010 SHALL have port write_select, input, DATA_WIDTH/8 bits: per-byte write mask, bit i covers byte lane i.
REQ-011 SHALL have port write_data, input, DATA_WIDTH bits: write payload.
REQ-012 SHALL have port read_data, output, DATA_WIDTH bits: registered read result.
REQ-013 SHALL have port acknowledge, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port error, output, 1 bit: out-of-range flag, valid while acknowledge is high.

Function
REQ-016 SHALL implement states IDLE, WAIT and DONE.
REQ-017 In IDLE, chip_enable=1 and request=1 SHALL capture write_enable, address, write_select and write_data, then go to WAIT if WAIT_CYCLES>0, else to DONE.
REQ-018 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and go to DONE on the cycle it reads 0.
REQ-019 The storage access SHALL occur on the edge that enters DONE: write the selected byte lanes only, or register the read word into read_data.
REQ-020 DONE SHALL last exactly one cycle with acknowledge=1, then return to IDLE; a new request is accepted no earlier than the IDLE cycle that follows.
REQ-021 The request-to-acknowledge latency SHALL be WAIT_CYCLES+1 cycles.
REQ-022 request, address and data inputs SHALL be ignored while busy=1.
REQ-023 read_data SHALL hold its value until the next completed read; a write SHALL leave it unchanged.
REQ-024 A write with write_select all-zero SHALL complete normally and modify no storage.
REQ-025 Storage SHALL be uninitialised; it is not cleared by reset.

Reset
REQ-026 Asserting reset SHALL immediately force: state IDLE, counter 0, read_data 0, acknowledge 0, busy 0, error 0.
REQ-027 Reset asserted during WAIT SHALL abandon the access: no storage write and no acknowledge.

Configuration
REQ-028 Macro RAM_RANGE_CHECK_EN SHALL control address range checking.
REQ-029 When RAM_RANGE_CHECK_EN is defined, a word index >= DEPTH SHALL set error=1 with acknowledge, suppress any write, and return read_data=0.
REQ-030 When RAM_RANGE_CHECK_EN is not defined, the index SHALL wrap modulo DEPTH, and error SHALL be tied to 0.

Structure
REQ-031 Package ram_pkg SHALL hold the state encoding, the enable/disable level constants, and the default parameter values.
REQ-032 The wait-state counter SHALL be sub-module ram_wait_counter, with inputs load, value and enable and output zero.

Verification
REQ-033 The bench SHALL cover, with WAIT_CYCLES=0: write 0xDEADBEEF to address 0x10 with write_select=4'hF, then read 0x10 -> acknowledge one cycle after each request, read_data=0xDEADBEEF.
REQ-034 The bench SHALL cover, with WAIT_CYCLES=3: a read request -> busy high for 4 cycles, acknowledge in the 4th, and request pulses during busy ignored.
REQ-035 The bench SHALL cover: a word holding 0x11223344, written with 0xAABBCCDD and write_select=4'b0101, then read back -> 0x11BB33DD.
REQ-036 The bench SHALL cover, with WAIT_CYCLES=5: write to address 0x20 previously holding 0x0, reset pulsed in cycle 2 -> no acknowledge, and a later read of 0x20 returns 0x0.
REQ-037 The bench SHALL cover, with RAM_RANGE_CHECK_EN defined and DEPTH=1024: write to address 0x1000 -> error=1 with acknowledge, and address 0x0 unchanged; with the macro undefined, the same write lands at word 0.
REQ-038 The bench SHALL cover: chip_enable=0 with request=1 for 3 cycles -> busy stays 0 and there is no acknowledge.
